// File: rtl/input_capture.sv
// -----------------------------------------------------------------------------
// input_capture
//
// Front-panel input block: synchronizes and debounces the four active-low
// push-buttons, exports clean levels and one-cycle press pulses, and builds
// an 8-digit hexadecimal entry from SW[3:0].
//
//   KEY[0] enter      : shift SW in as the newest digit (nibble 0)
//   KEY[1] clear      : zero all digits
//   KEY[2] backspace  : drop the newest digit
//   KEY[3] lock       : toggle the entry lock
//
// Optional feature macro: INPUT_CAPTURE_DECIMAL_EN
//   When defined, enter refuses SW values above 9 so the display stays BCD.
//
// All outputs are registered; KEY and SW reach outputs only through flops.
// -----------------------------------------------------------------------------
module input_capture #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic        CLOCK_50,
   input  logic        RESET_N,
   input  logic [3:0]  KEY,
   input  logic [3:0]  SW,
   output logic [3:0]  key_level,
   output logic [3:0]  key_press,
   output logic [31:0] digits,
   output logic [3:0]  digit_count,
   output logic        locked,
   output logic        entry_reject
);

   // Key roles within the KEY / key_press vectors.
   localparam int KEY_ENTER = 0;
   localparam int KEY_CLEAR = 1;
   localparam int KEY_BACK  = 2;
   localparam int KEY_LOCK  = 3;

   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]       MAX_DIGIT = 4'd8;

   // The single entry action selected from the current press pulses.
   typedef enum logic [1:0] {
      ACT_NONE,
      ACT_CLEAR,
      ACT_BACK,
      ACT_ENTER
   } action_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [3:0]       sync1_q,  sync1_d;
   logic [3:0]       sync2_q,  sync2_d;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       stable_q, stable_d;
   logic [3:0]       press_q,  press_d;
   logic [31:0]      digits_q, digits_d;
   logic [3:0]       count_q,  count_d;
   logic             locked_q, locked_d;
   logic             reject_q, reject_d;

   action_e          act;
   logic             sw_ok;

   // ---------------------------------------------------------------------------
   // Digit acceptance rule for enter
   // ---------------------------------------------------------------------------
`ifdef INPUT_CAPTURE_DECIMAL_EN
   assign sw_ok = (SW <= 4'd9);
`else
   assign sw_ok = 1'b1;
`endif

   // Two-flop synchronizer for the asynchronous keys.
   always_comb begin
      sync1_d = KEY;
      sync2_d = sync1_q;
   end

   // Per-key debounce: count consecutive cycles the synced key disagrees with
   // the stable state; flip the stable state on the last one.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path
      // leaves it unassigned; a missing default would infer a latch.
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         // Synced key is active-low; stable state is active-high.
         if (~sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = ~stable_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
      // Pulse only on the debounced press edge, never on release.
      press_d = stable_d & ~stable_q;
   end

   // Select the highest-priority entry action from this cycle's pulses.
   always_comb begin
      act = ACT_NONE;
      if (press_q[KEY_CLEAR]) begin
         act = ACT_CLEAR;
      end else if (press_q[KEY_BACK]) begin
         act = ACT_BACK;
      end else if (press_q[KEY_ENTER]) begin
         act = ACT_ENTER;
      end
   end

   // Apply the selected action; lock toggles first and its new value gates
   // the digit actions in the same cycle.
   always_comb begin
      locked_d = locked_q ^ press_q[KEY_LOCK];
      digits_d = digits_q;
      count_d  = count_q;
      reject_d = 1'b0;

      unique case (act)
         ACT_CLEAR: begin
            if (!locked_d) begin
               digits_d = '0;
               count_d  = '0;
            end
         end
         ACT_BACK: begin
            if (!locked_d) begin
               digits_d = {4'h0, digits_q[31:4]};
               if (count_q != 4'd0) begin
                  count_d = count_q - 4'd1;
               end
            end
         end
         ACT_ENTER: begin
            if (locked_d || !sw_ok) begin
               reject_d = 1'b1;
            end else begin
               // Oldest digit drops off the top once all eight are in use.
               digits_d = {digits_q[27:0], SW};
               if (count_q != MAX_DIGIT) begin
                  count_d = count_q + 4'd1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge CLOCK_50) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!RESET_N) begin
         sync1_q  <= 4'hF;
         sync2_q  <= 4'hF;
         // NOTE: the counter array is small control state, not a memory, so
         // it is reset; a mid-debounce reset must discard partial counts.
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         stable_q <= '0;
         press_q  <= '0;
         digits_q <= '0;
         count_q  <= '0;
         locked_q <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         stable_q <= stable_d;
         press_q  <= press_d;
         digits_q <= digits_d;
         count_q  <= count_d;
         locked_q <= locked_d;
         reject_q <= reject_d;
      end
   end

   // Registered outputs.
   always_comb begin
      key_level    = stable_q;
      key_press    = press_q;
      digits       = digits_q;
      digit_count  = count_q;
      locked       = locked_q;
      entry_reject = reject_q;
   end

endmodule

// File: tb/tb_input_capture.sv
// -----------------------------------------------------------------------------
// tb_input_capture
//
// Bench for input_capture with DEBOUNCE_CYCLES = 4. A behavioural model
// (sliding window of synced key samples, digit queue) runs beside the DUT
// and a compare process checks every output on every falling edge. Directed
// scenarios pin the model with literal expectations; a random phase follows.
// Honours INPUT_CAPTURE_DECIMAL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_input_capture;

   localparam int DC = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  key;
   logic [3:0]  sw;
   logic [3:0]  key_level;
   logic [3:0]  key_press;
   logic [31:0] digits;
   logic [3:0]  digit_count;
   logic        locked;
   logic        entry_reject;

   int total = 0;
   int bad   = 0;

   input_capture #(
      .DEBOUNCE_CYCLES (DC),
      .CNT_W           (3)
   ) dut (
      .CLOCK_50     (clk),
      .RESET_N      (rst_n),
      .KEY          (key),
      .SW           (sw),
      .key_level    (key_level),
      .key_press    (key_press),
      .digits       (digits),
      .digit_count  (digit_count),
      .locked       (locked),
      .entry_reject (entry_reject)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model
   // ---------------------------------------------------------------------------
   logic [3:0]    m_raw1, m_raw2;     // raw KEY one and two edges ago
   logic [DC-1:0] m_win [4];          // last DC synced "pressed" samples
   int            m_nsamp [4];        // samples seen since reset
   logic [3:0]    m_level, m_press;
   int            m_dq[$];            // entered digits, newest first
   logic          m_locked, m_reject;
   logic          m_nl;
   logic [3:0]    m_new_level;

   function automatic logic m_sw_ok(input logic [3:0] v);
`ifdef INPUT_CAPTURE_DECIMAL_EN
      return v <= 4'd9;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [31:0] m_digits();
      logic [31:0] v;
      v = '0;
      foreach (m_dq[k]) v = v | (32'(m_dq[k]) << (4 * k));
      return v;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_raw1   = 4'hF;
         m_raw2   = 4'hF;
         m_level  = '0;
         m_press  = '0;
         m_locked = 1'b0;
         m_reject = 1'b0;
         m_dq.delete();
         for (int i = 0; i < 4; i++) begin
            m_win[i]   = '0;
            m_nsamp[i] = 0;
         end
      end else begin
         // Entry actions from the previous cycle's press pulses.
         m_nl     = m_locked ^ m_press[3];
         m_reject = 1'b0;
         if (m_press[1]) begin
            if (!m_nl) m_dq.delete();
         end else if (m_press[2]) begin
            if (!m_nl && m_dq.size() > 0) void'(m_dq.pop_front());
         end else if (m_press[0]) begin
            if (m_nl || !m_sw_ok(sw)) begin
               m_reject = 1'b1;
            end else begin
               m_dq.push_front(int'(sw));
               if (m_dq.size() > 8) void'(m_dq.pop_back());
            end
         end
         m_locked = m_nl;

         // A key's level flips once its last DC synced samples all disagree.
         m_new_level = m_level;
         for (int i = 0; i < 4; i++) begin
            m_win[i] = {m_win[i][DC-2:0], ~m_raw2[i]};
            m_nsamp[i]++;
            if (m_nsamp[i] >= DC && m_win[i] == {DC{~m_level[i]}})
               m_new_level[i] = ~m_level[i];
         end
         m_press = m_new_level & ~m_level;
         m_level = m_new_level;
         m_raw2  = m_raw1;
         m_raw1  = key;
      end
   end

   // ---------------------------------------------------------------------------
   // Compare process and event monitors
   // ---------------------------------------------------------------------------
   logic chk_en = 1'b0;
   int   press_cnt [4];
   int   rej_cnt = 0;

   initial for (int i = 0; i < 4; i++) press_cnt[i] = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("key_level",    32'(key_level),    32'(m_level));
         check("key_press",    32'(key_press),    32'(m_press));
         check("digits",       digits,            m_digits());
         check("digit_count",  32'(digit_count),  32'(m_dq.size()));
         check("locked",       32'(locked),       32'(m_locked));
         check("entry_reject", 32'(entry_reject), 32'(m_reject));
      end
      for (int i = 0; i < 4; i++) if (key_press[i] === 1'b1) press_cnt[i]++;
      if (entry_reject === 1'b1) rej_cnt++;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change on falling edges)
   // ---------------------------------------------------------------------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tap(input logic [3:0] mask, input logic [3:0] val);
      sw  = val;
      key = ~mask;
      step(10);
      key = 4'hF;
      step(8);
   endtask

   int p0, r0;

   initial begin
      rst_n = 1'b0;
      key   = 4'hF;
      sw    = 4'h0;
      step(3);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      step(1);

      // Reset state
      check("rst_level",  32'(key_level),   32'h0);
      check("rst_digits", digits,           32'h0);
      check("rst_count",  32'(digit_count), 32'h0);
      check("rst_locked", 32'(locked),      32'h0);

      // Clean press: level 6 cycles after the edge, single pulse, no release pulse
      p0  = press_cnt[0];
      key = 4'b1110;
      step(5);
      check("press_early_level", 32'(key_level[0]), 32'h0);
      step(1);
      check("press_level", 32'(key_level[0]), 32'h1);
      check("press_pulse", 32'(key_press[0]), 32'h1);
      step(1);
      check("press_pulse_end", 32'(key_press[0]), 32'h0);
      step(3);
      key = 4'hF;
      step(8);
      check("release_level", 32'(key_level[0]), 32'h0);
      check("press_once", 32'(press_cnt[0] - p0), 32'd1);
      check("first_digit", digits, 32'h0);
      check("first_count", 32'(digit_count), 32'd1);

      // Bounce: toggling every 2 cycles must never debounce
      tap(4'b0010, 4'h0);
      p0 = press_cnt[0];
      for (int k = 0; k < 5; k++) begin
         key = 4'b1110; step(2);
         key = 4'b1111; step(2);
      end
      step(8);
      check("bounce_no_press", 32'(press_cnt[0] - p0), 32'd0);
      check("bounce_digits", digits, 32'h0);

      // Entry and wrap
      for (int v = 1; v <= 9; v++) tap(4'b0001, 4'(v));
      check("wrap_digits", digits, 32'h23456789);
      check("wrap_count",  32'(digit_count), 32'd8);
      tap(4'b0100, 4'h0);
      check("bksp_digits", digits, 32'h02345678);
      check("bksp_count",  32'(digit_count), 32'd7);

      // Clear and enter together: clear wins
      tap(4'b0011, 4'h7);
      check("prio_digits", digits, 32'h0);
      check("prio_count",  32'(digit_count), 32'd0);

      // Lock rejects enter
      tap(4'b0001, 4'h3);
      tap(4'b1000, 4'h0);
      check("lock_on", 32'(locked), 32'h1);
      r0 = rej_cnt;
      tap(4'b0001, 4'h5);
      check("lock_reject", 32'(rej_cnt - r0), 32'd1);
      check("lock_digits", digits, 32'h3);
      tap(4'b1000, 4'h0);
      check("lock_off", 32'(locked), 32'h0);

      // Mid-operation reset with KEY[2] held and its counter at 2
      tap(4'b0001, 4'h6);
      key = 4'b1011;
      step(4);
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      check("mrst_level",  32'(key_level),   32'h0);
      check("mrst_digits", digits,           32'h0);
      check("mrst_count",  32'(digit_count), 32'h0);
      p0 = press_cnt[2];
      step(5);
      check("mrst_no_early", 32'(press_cnt[2] - p0), 32'd0);
      step(1);
      check("mrst_redebounce", 32'(key_press[2]), 32'h1);
      key = 4'hF;
      step(8);

`ifdef INPUT_CAPTURE_DECIMAL_EN
      // Decimal-only entry
      tap(4'b0001, 4'h4);
      r0 = rej_cnt;
      tap(4'b0001, 4'hA);
      check("dec_reject", 32'(rej_cnt - r0), 32'd1);
      check("dec_count",  32'(digit_count), 32'd1);
      tap(4'b0001, 4'h9);
      check("dec_accept", digits, 32'h49);
`endif

      // Random phase
      for (int n = 0; n < 400; n++) begin
         logic [3:0] kv;
         kv = 4'hF;
         for (int b = 0; b < 4; b++) if ($urandom_range(2, 0) == 0) kv[b] = 1'b0;
         key = kv;
         sw  = 4'($urandom);
         if ($urandom_range(59, 0) == 0) begin
            rst_n = 1'b0;
            step(1);
            rst_n = 1'b1;
         end
         step($urandom_range(12, 1));
      end
      key = 4'hF;
      step(10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
